// File: rtl/dmem_mmio.sv
// dmem_mmio: word-addressed data RAM plus an MMIO window holding a TX FIFO, a STATUS register and a free-running CYCLE counter.
// Latency: readdata is combinational (zero cycles); stores, pushes, pops and counter updates land on the next rising clk edge.
// Backpressure: FIFO head is offered on out_valid/out_ready; a push to a full FIFO is dropped (sticky overflow) unless a pop frees a slot that cycle.
module dmem_mmio #(
  parameter int n          = 32,
  parameter int DEPTH      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memwrite,
  input  logic [n-1:0] dataadr,
  input  logic [n-1:0] writedata,
  output logic [n-1:0] readdata,
  output logic [n-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Storage: RAM is never reset; FIFO payload is don't-care while empty.
  logic [n-1:0]  ram_q  [DEPTH];
  logic [n-1:0]  fifo_q [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [n-1:0]  cyc_q, cyc_d;

  logic          is_io;
  logic [1:0]    io_off;
  logic [AW-1:0] ram_idx;
  logic          fifo_empty, fifo_full;
  logic          push_req, push_ok, pop, drop;
  logic          ovf_clr, cyc_wr, ram_wr;
  logic [n-1:0]  status;
  logic          unused_addr;

  // Address decode: top bit picks I/O, byte-lane bits and RAM-alias bits are ignored.
  assign is_io       = dataadr[n-1];
  assign io_off      = dataadr[3:2];
  assign ram_idx     = dataadr[AW+1:2];
  assign unused_addr = ^dataadr;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign pop      = out_valid && out_ready;
  assign push_req = memwrite && is_io && (io_off == 2'd0);
  assign push_ok  = push_req && (!fifo_full || pop);
  assign drop     = push_req && !push_ok;
  assign ovf_clr  = memwrite && is_io && (io_off == 2'd1) && writedata[2];
  assign cyc_wr   = memwrite && is_io && (io_off == 2'd2);
  assign ram_wr   = memwrite && !is_io;

  // STATUS word: empty, full, sticky overflow and occupancy.
  always_comb begin
    status      = '0;
    status[0]   = fifo_empty;
    status[1]   = fifo_full;
    status[2]   = ovf_q;
    status[7:4] = 4'(count_q);
  end

  // Next-state for FIFO pointers/occupancy, overflow flag (set beats clear) and counter (load beats increment).
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    cyc_d    = cyc_q + n'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    if (cyc_wr) cyc_d = writedata;
  end

  // Control state; reset empties the FIFO asynchronously so out_valid drops at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      cyc_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cyc_q    <= cyc_d;
    end
  end

  // Payload writes for RAM and FIFO slots; no reset so RAM survives it.
  always_ff @(posedge clk) begin
    if (ram_wr)  ram_q[ram_idx]   <= writedata;
    if (push_ok) fifo_q[wr_ptr_q] <= writedata;
  end

  // Combinational load mux back to the CPU; TXDATA and offset 3 read as zero.
  always_comb begin
    readdata = '0;
    if (!is_io) begin
      readdata = ram_q[ram_idx];
    end else begin
      case (io_off)
        2'd1:    readdata = status;
        2'd2:    readdata = cyc_q;
        default: readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed scenarios then randomized traffic, checked against a queue/array reference model.
module tb_dmem_mmio;

  localparam logic [31:0] TX = 32'h8000_0000;
  localparam logic [31:0] ST = 32'h8000_0004;
  localparam logic [31:0] CY = 32'h8000_0008;
  localparam logic [31:0] R3 = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  dmem_mmio #(.n(32), .DEPTH(64), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays, a queue for the FIFO, integers for flags.
  logic [31:0] mram   [64];
  bit          mknown [64];
  logic [31:0] mq [$];
  logic        movf;
  logic [31:0] mcyc;

  int    checks    = 0;
  int    failures  = 0;
  string step_name = "init";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%h expected=%h", step_name, tag, got, exp);
    end
  endtask

  task automatic mreset();
    mq.delete();
    movf = 1'b0;
    mcyc = 32'h0;
  endtask

  // Returns {known, value} for a load at adr given the current model state.
  function automatic logic [32:0] mread(input logic [31:0] adr);
    logic [31:0] st;
    int          cnt;
    if (!adr[31]) return {mknown[adr[7:2]], mram[adr[7:2]]};
    cnt   = mq.size();
    st    = 32'(cnt) << 4;
    st[0] = (cnt == 0);
    st[1] = (cnt == 4);
    st[2] = movf;
    case (adr[3:2])
      2'd1:    return {1'b1, st};
      2'd2:    return {1'b1, mcyc};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // Applies one clock edge worth of effects to the model.
  task automatic mstep(input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic rdy);
    if (rdy && mq.size() != 0) void'(mq.pop_front());
    mcyc = mcyc + 32'h1;
    if (we && !adr[31]) begin
      mram[adr[7:2]]   = wd;
      mknown[adr[7:2]] = 1'b1;
    end
    if (we && adr[31]) begin
      case (adr[3:2])
        2'd0:    if (mq.size() < 4) mq.push_back(wd); else movf = 1'b1;
        2'd1:    if (wd[2]) movf = 1'b0;
        2'd2:    mcyc = wd;
        default: ;
      endcase
    end
  endtask

  // One CPU cycle: drive, check loads and the FIFO port against the model, clock, update model.
  task automatic cyc(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                     input logic rdy, input logic use_exp, input logic [31:0] exp_v);
    logic [32:0] r;
    memwrite  = we;
    dataadr   = adr;
    writedata = wd;
    out_ready = rdy;
    #1;
    r = mread(adr);
    if (r[32]) chk("readdata", readdata, r[31:0]);
    if (use_exp) chk("directed", readdata, exp_v);
    chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
    if (mq.size() != 0) chk("out_data", out_data, mq[0]);
    @(posedge clk);
    mstep(we, adr, wd, rdy);
    #1;
  endtask

  logic [31:0] heads [4];

  initial begin
    reset = 1'b0; memwrite = 1'b0; dataadr = ST; writedata = 32'h0; out_ready = 1'b0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    step_name = "reset";
    chk("status", readdata, 32'h1);
    chk("out_valid", {31'b0, out_valid}, 32'h0);
    dataadr = CY;
    #1;
    chk("cycle", readdata, 32'h0);
    reset = 1'b1;

    step_name = "ram_fill";
    for (int i = 0; i < 64; i++) cyc(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0, 32'h0);

    step_name = "ram_roundtrip";
    cyc(1'b1, 32'h10,  32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 32'h10,  32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    cyc(1'b0, 32'h110, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);

    step_name = "fifo_fill";
    for (int v = 1; v <= 4; v++) cyc(1'b1, TX, 32'(v), 1'b0, 1'b0, 32'h0);
    cyc(1'b0, ST, 32'h0, 1'b0, 1'b1, 32'h42);
    cyc(1'b1, TX, 32'h5, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, ST, 32'h0, 1'b0, 1'b1, 32'h46);

    step_name = "fifo_drain";
    for (int k = 0; k < 4; k++) begin
      chk("head", out_data, 32'(k + 1));
      cyc(1'b0, R3, 32'h0, 1'b1, 1'b0, 32'h0);
    end
    chk("drained", {31'b0, out_valid}, 32'h0);

    step_name = "full_push_pop";
    for (int v = 10; v <= 13; v++) cyc(1'b1, TX, 32'(v), 1'b0, 1'b0, 32'h0);
    cyc(1'b1, TX, 32'h9, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, ST, 32'h0, 1'b0, 1'b1, 32'h46);
    heads[0] = 32'd11; heads[1] = 32'd12; heads[2] = 32'd13; heads[3] = 32'd9;
    for (int k = 0; k < 4; k++) begin
      chk("head", out_data, heads[k]);
      cyc(1'b0, TX, 32'h0, 1'b1, 1'b1, 32'h0);
    end
    chk("drained", {31'b0, out_valid}, 32'h0);

    step_name = "ovf_clear";
    cyc(1'b1, ST, 32'h4, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, ST, 32'h0, 1'b0, 1'b1, 32'h1);

    step_name = "counter_wrap";
    cyc(1'b1, CY, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, CY, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    cyc(1'b0, CY, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    cyc(1'b0, CY, 32'h0, 1'b0, 1'b1, 32'h0);

    step_name = "offset3";
    cyc(1'b1, R3, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, R3, 32'h0, 1'b0, 1'b1, 32'h0);

    step_name = "mid_reset";
    cyc(1'b1, TX, 32'h77, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, TX, 32'h78, 1'b0, 1'b0, 32'h0);
    chk("two_entries", {31'b0, out_valid}, 32'h1);
    memwrite = 1'b0; out_ready = 1'b0; dataadr = ST;
    #2;
    reset = 1'b0;
    #1;
    mreset();
    chk("async_valid", {31'b0, out_valid}, 32'h0);
    chk("status_in_reset", readdata, 32'h1);
    @(posedge clk);
    #1;
    dataadr = CY;
    #1;
    chk("cycle_in_reset", readdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(1'b0, CY, 32'h0, 1'b0, 1'b1, 32'h0);
    cyc(1'b0, CY, 32'h0, 1'b0, 1'b1, 32'h1);
    cyc(1'b0, ST, 32'h0, 1'b0, 1'b1, 32'h1);
    cyc(1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);

    step_name = "random";
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a;
      logic [1:0]  off;
      logic        we;
      off = 2'($urandom_range(0, 5) > 3 ? 0 : $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) a = {1'b0, 31'($urandom)};
      else                           a = {1'b1, 27'($urandom), off, 2'($urandom)};
      we = ($urandom_range(0, 2) != 0);
      cyc(we, a, $urandom, 1'($urandom), 1'b0, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
